// File: rtl/alu_muldiv_if.sv
// Handshake and operand/result bundle between the datapath and the alu_muldiv execution unit.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [3:0]       ALUS;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, ALUS, A, B,
        input  Result, Zero, Busy, Done, HI, LO
    );

    modport slave (
        input  Start, ALUS, A, B,
        output Result, Zero, Busy, Done, HI, LO
    );
endinterface

// File: rtl/alu_muldiv.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative signed MULT/DIV into HI/LO.
// Define ALU_DIV_EN to build the restoring divider; without it DIV is an undefined code.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b0101;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'b1000;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef ALU_DIV_EN
    logic             is_div_q, is_div_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [PW-1:0]    div_next;
    logic [WIDTH-1:0] quo_fix, rem_fix;
`endif

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    mul_next, prod_fix;

    assign abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // Shift-add step: acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (acc_q[0] ? opd_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef ALU_DIV_EN
    // Restoring step: acc holds {partial remainder, dividend bits shifting into quotient}
    assign div_shift = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opd_q};
    assign div_next  = div_trial[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quo_fix   = neg_q  ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
    assign rem_fix   = rneg_q ? -acc_q[PW-1:WIDTH] : acc_q[PW-1:WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        neg_d    = neg_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef ALU_DIV_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
`endif

        case (state_q)
            // DONE behaves like IDLE so a new Start is accepted in the Done cycle
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.Start) begin
                    done_d = 1'b1;
                    case (bus.ALUS)
                        OP_AND:  result_d = bus.A & bus.B;
                        OP_OR:   result_d = bus.A | bus.B;
                        OP_ADD:  result_d = bus.A + bus.B;
                        OP_SUB:  result_d = bus.A - bus.B;
                        OP_SLT:  result_d = WIDTH'($signed(bus.A) < $signed(bus.B));
                        OP_MULT: begin
                            done_d   = 1'b0;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opd_d    = abs_b;
                            neg_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            cnt_d    = CW'(WIDTH);
                            state_d  = CALC;
`ifdef ALU_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef ALU_DIV_EN
                        OP_DIV: begin
                            if (bus.B == '0) begin
                                lo_d     = '1;
                                hi_d     = bus.A;
                                result_d = '1;
                            end else begin
                                done_d   = 1'b0;
                                acc_d    = {{WIDTH{1'b0}}, abs_a};
                                opd_d    = abs_b;
                                neg_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                                rneg_d   = bus.A[WIDTH-1];
                                is_div_d = 1'b1;
                                cnt_d    = CW'(WIDTH);
                                state_d  = CALC;
                            end
                        end
`endif
                        default: result_d = '0;
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
`ifdef ALU_DIV_EN
                acc_d = is_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
`ifdef ALU_DIV_EN
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[PW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
`else
                hi_d = prod_fix[PW-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
`endif
                result_d = lo_d;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef ALU_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef ALU_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign bus.Result = result_q;
    assign bus.Zero   = zero_q;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
endmodule
